uart_rx_ext: RTL and testbench

Parametrised UART receiver, successor to the team's fixed 8N1 receiver.
- Configurable data width, parity and stop bits; 16x oversampling with 3-sample majority vote; input synchroniser.
- Valid/ready output handshake; parity, framing and overrun error flags.
- Sits between the pad-level rx line and the host-side byte sink (FIFO or command decoder).

---
 rtl/uart_rx_ext.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: synchroniser, oversampled 3-sample majority vote,
// optional parity/2 stop bits, valid/ready delivery. Optional break detect: UART_RX_BREAK_DETECT_EN.
module uart_rx_ext #(
   parameter int unsigned CLOCK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                 break_det,
`endif
   output logic                 busy
);

   localparam int unsigned DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SW      = $clog2(OVERSAMPLE);
   localparam int unsigned BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned S_LO    = OVERSAMPLE / 2 - 1;
   localparam int unsigned S_MID   = OVERSAMPLE / 2;
   localparam int unsigned S_HI    = OVERSAMPLE / 2 + 1;
   localparam int unsigned S_END   = OVERSAMPLE - 1;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rx_prev_q, rx_prev_d;
   logic [CW-1:0]          div_q, div_d;
   logic [SW-1:0]          samp_q, samp_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic                   stop_q, stop_d;
   logic [1:0]             smp_q, smp_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
   logic [DATA_BITS-1:0]   data_out_q, data_out_d;
   logic                   dv_q, dv_d, perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
   logic                   ovr_q, ovr_d, busy_q, busy_d;
   logic                   rx_s, tick, vote, bit_end, maj;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                   hi_q, hi_d, brk_q, brk_d;
   logic [SW-1:0]          hcnt_q, hcnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_d  = rx_s;
      samp_d     = samp_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      smp_d      = smp_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      done_d     = 1'b0;
      data_out_d = data_out_q;
      dv_d       = dv_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      ovr_d      = 1'b0;
      rx_s       = sync_q[SYNC_STAGES-1];
      tick       = (div_q == CW'(DIV - 1));
      div_d      = tick ? '0 : div_q + CW'(1);
      vote       = tick && (samp_q == SW'(S_HI));
      bit_end    = tick && (samp_q == SW'(S_END));
      maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
`ifdef UART_RX_BREAK_DETECT_EN
      hi_d       = hi_q;
      brk_d      = brk_q;
      hcnt_d     = hcnt_q;
`endif

      // Oversample counter and the two early samples; the third is rx_s at the vote
      if (tick) begin
         samp_d = bit_end ? '0 : samp_q + SW'(1);
         if (samp_q == SW'(S_LO))  smp_d[0] = rx_s;
         if (samp_q == SW'(S_MID)) smp_d[1] = rx_s;
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d = ST_START;
               div_d   = '0;
               samp_d  = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
               hi_d    = 1'b0;
`endif
            end
         end
         ST_START: begin
            if (vote && maj)  state_d = ST_IDLE;
            else if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (vote) shift_d[bit_q] = maj;
            if (bit_end) begin
               if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               else                             bit_d   = bit_q + BW'(1);
            end
         end
         ST_PARITY: begin
            if (vote)    perr_d  = maj ^ (^shift_q) ^ (PARITY == 1);
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Last stop bit ends at its vote so an immediately following start edge is caught
            if (vote) begin
               if (!maj) ferr_d = 1'b1;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (bit_end) begin
               stop_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef UART_RX_BREAK_DETECT_EN
      if (vote && maj && (state_q inside {ST_DATA, ST_PARITY, ST_STOP})) hi_d = 1'b1;
      if (brk_q) begin
         if (!rx_s) hcnt_d = '0;
         else if (tick) begin
            if (hcnt_q == SW'(S_END)) begin
               brk_d  = 1'b0;
               hcnt_d = '0;
            end else begin
               hcnt_d = hcnt_q + SW'(1);
            end
         end
      end
`endif

      if (dv_q && data_ready) dv_d = 1'b0;
      if (done_q) begin
`ifdef UART_RX_BREAK_DETECT_EN
         if (!hi_q) begin
            brk_d  = 1'b1;
            hcnt_d = '0;
         end else
`endif
         if (!dv_q || data_ready) begin
            data_out_d = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q;
            dv_d       = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sync_q     <= '1;
         rx_prev_q  <= 1'b1;
         div_q      <= '0;
         samp_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         smp_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
         data_out_q <= '0;
         dv_q       <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         hi_q       <= 1'b0;
         brk_q      <= 1'b0;
         hcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         rx_prev_q  <= rx_prev_d;
         div_q      <= div_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         stop_q     <= stop_d;
         smp_q      <= smp_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         done_q     <= done_d;
         data_out_q <= data_out_d;
         dv_q       <= dv_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
`ifdef UART_RX_BREAK_DETECT_EN
         hi_q       <= hi_d;
         brk_q      <= brk_d;
         hcnt_q     <= hcnt_d;
`endif
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = dv_q;
   assign parity_err  = perr_out_q;
   assign frame_err   = ferr_out_q;
   assign overrun_err = ovr_q;
   assign busy        = busy_q;
`ifdef UART_RX_BREAK_DETECT_EN
   assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 receiver and a 7E2 receiver at 16 clk per bit,
// directed scenarios plus random frames against a frame-level scoreboard.
module tb_uart_rx_ext;

   typedef struct packed {
      logic [8:0] d;
      logic       p;
      logic       f;
   } word_t;

`ifdef UART_RX_BREAK_DETECT_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif
   localparam int BIT_CLKS = 16;

   logic       clk, rst, rx0, rx1, rdy0, rdy1;
   logic [7:0] dout0;
   logic [6:0] dout1;
   logic       dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1, bz0, bz1;
`ifdef UART_RX_BREAK_DETECT_EN
   logic       bd0, bd1;
`endif

   uart_rx_ext #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut0 (
      .clk(clk), .rst(rst), .rx(rx0), .data_out(dout0), .data_valid(dv0), .data_ready(rdy0),
      .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0),
`ifdef UART_RX_BREAK_DETECT_EN
      .break_det(bd0),
`endif
      .busy(bz0));

   uart_rx_ext #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut1 (
      .clk(clk), .rst(rst), .rx(rx1), .data_out(dout1), .data_valid(dv1), .data_ready(rdy1),
      .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1),
`ifdef UART_RX_BREAK_DETECT_EN
      .break_det(bd1),
`endif
      .busy(bz1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec = 0, n_miscmp = 0;
   word_t exp0[$], exp1[$], got0[$], got1[$];
   int    vc0 = 0, oc0 = 0, bc0 = 0, vc1 = 0, oc1 = 0;
   logic  p0 = 0, t0 = 0, p1 = 0, t1 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Collect each newly presented word and count per-cycle activity
   always @(negedge clk) begin
      if (rst) begin
         p0 = 0; t0 = 0; p1 = 0; t1 = 0;
      end else begin
         if (dv0 && (!p0 || t0)) got0.push_back({9'(dout0), pe0, fe0});
         if (dv1 && (!p1 || t1)) got1.push_back({9'(dout1), pe1, fe1});
         p0 = dv0; t0 = dv0 && rdy0;
         p1 = dv1; t1 = dv1 && rdy1;
         vc0 += int'(dv0); oc0 += int'(ov0); bc0 += int'(bz0);
         vc1 += int'(dv1); oc1 += int'(ov1);
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input int sel, input logic v);
      if (sel != 0) rx1 = v;
      else          rx0 = v;
   endtask

   // One frame on the selected line; the expected word comes from the frame contents
   task automatic send(input int sel, input logic [8:0] d, input bit flip, input bit stop_low,
                       input bit exp_word);
      int         nb   = (sel != 0) ? 7 : 8;
      int         ns   = (sel != 0) ? 2 : 1;
      bit         hasp = (sel != 0);
      logic [8:0] dm;
      logic       pbit;
      bit         brk;
      word_t      w;
      dm   = d & ((9'(1) << nb) - 9'(1));
      pbit = (^dm) ^ flip;
      line(sel, 1'b0); wait_clks(BIT_CLKS);
      for (int i = 0; i < nb; i++) begin
         line(sel, dm[i]); wait_clks(BIT_CLKS);
      end
      if (hasp) begin
         line(sel, pbit); wait_clks(BIT_CLKS);
      end
      for (int i = 0; i < ns; i++) begin
         line(sel, !stop_low); wait_clks(BIT_CLKS);
      end
      line(sel, 1'b1);
      w.d = dm; w.p = hasp && flip; w.f = stop_low;
      brk = (dm == 9'd0) && (!hasp || !pbit) && stop_low;
      if (exp_word && !(BRK_EN && brk)) begin
         if (sel != 0) exp1.push_back(w);
         else          exp0.push_back(w);
      end
   endtask

   task automatic flush(input string tag);
      chk($sformatf("%s.count0", tag), 32'(got0.size()), 32'(exp0.size()));
      chk($sformatf("%s.count1", tag), 32'(got1.size()), 32'(exp1.size()));
      for (int i = 0; i < got0.size() && i < exp0.size(); i++)
         chk($sformatf("%s.word0[%0d]", tag, i), 32'(got0[i]), 32'(exp0[i]));
      for (int i = 0; i < got1.size() && i < exp1.size(); i++)
         chk($sformatf("%s.word1[%0d]", tag, i), 32'(got1[i]), 32'(exp1[i]));
      got0.delete(); exp0.delete(); got1.delete(); exp1.delete();
   endtask

   initial begin
      int v, o, b;
      rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
      wait_clks(5);
      chk("rst_dv0", 32'(dv0), 0);
      chk("rst_dout0", 32'(dout0), 0);
      chk("rst_flags0", 32'({pe0, fe0, ov0, bz0}), 0);
      chk("rst_out1", 32'({dout1, dv1, pe1, fe1, ov1, bz1}), 0);
      rst = 1'b0;
      wait_clks(5);
      chk("idle_busy0", 32'(bz0), 0);

      // 8N1 0xA5 with ready held high
      v = vc0; b = bc0;
      send(0, 9'h0A5, 0, 0, 1);
      chk("t1_busy_done", 32'(bz0), 0);
      chk("t1_valid_cycles", 32'(vc0 - v), 1);
      chk("t1_busy_len_ok", 32'((bc0 - b) >= 9 * BIT_CLKS && (bc0 - b) <= 10 * BIT_CLKS), 1);
      wait_clks(10);
      flush("t1");

      // 7E2: good parity then flipped parity
      send(1, 9'h053, 0, 0, 1); wait_clks(5);
      send(1, 9'h053, 1, 0, 1); wait_clks(10);
      flush("t2");

      // Low stop bit, then a clean frame
      send(0, 9'h096, 0, 1, 1); wait_clks(4);
      send(0, 9'h03C, 0, 0, 1); wait_clks(10);
      flush("t3");

      // Overrun with sink stalled, then release
      rdy0 = 1'b0; o = oc0;
      send(0, 9'h011, 0, 0, 1);
      send(0, 9'h022, 0, 0, 0);
      wait_clks(5);
      chk("t4_hold_data", 32'(dout0), 32'h11);
      chk("t4_hold_valid", 32'(dv0), 1);
      chk("t4_overrun_pulses", 32'(oc0 - o), 1);
      rdy0 = 1'b1;
      @(negedge clk);
      chk("t4_valid_before_edge", 32'(dv0), 1);
      @(negedge clk);
      chk("t4_valid_dropped", 32'(dv0), 0);
      wait_clks(5);
      flush("t4");

      // Short glitch is a false start
      v = vc0;
      line(0, 1'b0); wait_clks(6); line(0, 1'b1);
      wait_clks(3 * BIT_CLKS);
      chk("t5_glitch_novalid", 32'(vc0 - v), 0);
      chk("t5_glitch_idle", 32'(bz0), 0);

      // Reset in the middle of the data bits
      line(0, 1'b0); wait_clks(BIT_CLKS);
      line(0, 1'b0); wait_clks(BIT_CLKS);
      line(0, 1'b1); wait_clks(BIT_CLKS + 8);
      chk("t5_busy_midframe", 32'(bz0), 1);
      rst = 1'b1; rx0 = 1'b1;
      wait_clks(3);
      chk("t5_rst_out0", 32'({dout0, dv0, pe0, fe0, ov0, bz0}), 0);
      rst = 1'b0;
      wait_clks(2 * BIT_CLKS);
      send(0, 9'h07E, 0, 0, 1); wait_clks(10);
      flush("t5");

`ifdef UART_RX_BREAK_DETECT_EN
      // Line held low for 12 bit times
      v = vc0; o = oc0;
      chk("t6_brk_initial", 32'(bd0), 0);
      line(0, 1'b0); wait_clks(12 * BIT_CLKS);
      chk("t6_brk_set", 32'(bd0), 1);
      chk("t6_brk_novalid", 32'(vc0 - v), 0);
      chk("t6_brk_nooverrun", 32'(oc0 - o), 0);
      line(0, 1'b1); wait_clks(8);
      chk("t6_brk_held", 32'(bd0), 1);
      wait_clks(20);
      chk("t6_brk_clear", 32'(bd0), 0);
      flush("t6");
`endif

      // Random frames on both receivers
      for (int n = 0; n < 60; n++) begin
         int         sel;
         logic [8:0] d;
         bit         flip, sl;
         sel  = int'($urandom_range(0, 1));
         d    = 9'($urandom);
         flip = (sel != 0) && ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 4) == 0);
         send(sel, d, flip, sl, 1);
         wait_clks(int'($urandom_range(3, 20)));
      end
      wait_clks(BIT_CLKS);
      flush("rand");
      chk("rand_no_overrun", 32'(oc0 + oc1), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
